// File: rtl/comparator_pkg.sv
// comparator_pkg -- shared constants and helpers for the sensor-vote comparator.
//   FLAG_* : 3-bit vote-pattern classification codes driven on Flag
//   VOTE_W : width of the vote count (0..4)
//   MAJORITY : vote count at which an event is considered trustworthy
//   vote_count() / classify() : combinational helpers on the 4-bit sensor
//   vector {SoilMoisture, AirHumidity, SoilTemprature, AirTemperature}
package comparator_pkg;

  localparam logic [2:0] FLAG_NONE  = 3'b000;
  localparam logic [2:0] FLAG_AT    = 3'b001;
  localparam logic [2:0] FLAG_ST    = 3'b010;
  localparam logic [2:0] FLAG_AH    = 3'b011;
  localparam logic [2:0] FLAG_SM    = 3'b100;
  localparam logic [2:0] FLAG_TWO   = 3'b101;
  localparam logic [2:0] FLAG_THREE = 3'b110;
  localparam logic [2:0] FLAG_ALL   = 3'b111;

  localparam int VOTE_W = 3;
  localparam logic [VOTE_W-1:0] MAJORITY = 3'd3;

  function automatic logic [VOTE_W-1:0] vote_count(input logic [3:0] s);
    logic [VOTE_W-1:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, s[i]};
    return n;
  endfunction

  function automatic logic [2:0] classify(input logic [3:0] s);
    logic [2:0] f;
    f = FLAG_NONE;
    case (vote_count(s))
      3'd0: f = FLAG_NONE;
      3'd1: begin
        // A lone sensor is reported by identity so it can be treated as a fault.
        case (s)
          4'b0001: f = FLAG_AT;
          4'b0010: f = FLAG_ST;
          4'b0100: f = FLAG_AH;
          4'b1000: f = FLAG_SM;
          default: f = FLAG_NONE;
        endcase
      end
      3'd2:    f = FLAG_TWO;
      3'd3:    f = FLAG_THREE;
      default: f = FLAG_ALL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparator_sync.sv
// comparator_sync -- single-bit synchronizer of STAGES flops (2..4).
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears all stages
//   d   : asynchronous input
//   q   : synchronized output, STAGES cycles behind d
module comparator_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/comparator.sv
// comparator -- majority vote over four asynchronous sensor indications
// with a persistence filter on the registered result.
//   clk            : sole clock
//   rst            : asynchronous active-high reset
//   AirTemperature, SoilTemprature, AirHumidity, SoilMoisture : async sensor inputs
//   Output         : 1 when at least three synchronized sensors are high
//   Flag           : vote-pattern classification code (comparator_pkg::FLAG_*)
//   fault_sticky   : only when COMPARATOR_FAULT_LATCH_EN is defined; one bit
//                    per sensor, set when a registered Flag names it as the
//                    lone active sensor, cleared only by rst
// Parameters: SYNC_STAGES (2..4), MIN_HOLD (1..255).
// Latency from an input edge to the outputs is SYNC_STAGES + MIN_HOLD cycles.
module comparator
  import comparator_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AirTemperature,
  input  logic       SoilTemprature,
  input  logic       AirHumidity,
  input  logic       SoilMoisture,
  output logic       Output,
  output logic [2:0] Flag
`ifdef COMPARATOR_FAULT_LATCH_EN
  ,
  output logic [3:0] fault_sticky
`endif
);

  localparam logic [7:0] HOLD_LOAD = 8'(MIN_HOLD - 1);

  logic [3:0] raw;
  logic [3:0] sens;

  assign raw = {SoilMoisture, AirHumidity, SoilTemprature, AirTemperature};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    comparator_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw[i]),
      .q   (sens[i])
    );
  end

  logic [VOTE_W-1:0] votes;
  logic [3:0]        cand;
  logic [3:0]        prev_cand;
  logic [7:0]        hold_cnt;
  logic [7:0]        hold_nxt;

  always_comb begin
    votes = vote_count(sens);
    cand  = {(votes >= MAJORITY), classify(sens)};
  end

  // Down-counter restarts whenever the candidate changes; the candidate is
  // committed on the cycle the count reaches zero, i.e. its MIN_HOLD-th
  // consecutive cycle. Short-lived intermediate patterns never reach zero.
  always_comb begin
    hold_nxt = hold_cnt;
    if (cand != prev_cand)  hold_nxt = HOLD_LOAD;
    else if (hold_cnt != 0) hold_nxt = hold_cnt - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cand <= 4'b0000;
      hold_cnt  <= '0;
      Output    <= 1'b0;
      Flag      <= FLAG_NONE;
    end else begin
      prev_cand <= cand;
      hold_cnt  <= hold_nxt;
      if (hold_nxt == 0) begin
        Output <= cand[3];
        Flag   <= cand[2:0];
      end
    end
  end

`ifdef COMPARATOR_FAULT_LATCH_EN
  logic [3:0] lone;

  always_comb begin
    lone = 4'b0000;
    case (Flag)
      FLAG_AT: lone = 4'b0001;
      FLAG_ST: lone = 4'b0010;
      FLAG_AH: lone = 4'b0100;
      FLAG_SM: lone = 4'b1000;
      default: lone = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_sticky <= 4'b0000;
    else     fault_sticky <= fault_sticky | lone;
  end
`endif

endmodule

// File: tb/tb_comparator.sv
module tb_comparator;

  logic       clk;
  logic       rst;
  logic       air_t, soil_t, air_h, soil_m;
  logic       out1, out4;
  logic [2:0] flag1, flag4;
`ifdef COMPARATOR_FAULT_LATCH_EN
  logic [3:0] sticky1, sticky4;
`endif

  int checks = 0;
  int errors = 0;

  comparator #(.SYNC_STAGES(2), .MIN_HOLD(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .AirTemperature (air_t),
    .SoilTemprature (soil_t),
    .AirHumidity    (air_h),
    .SoilMoisture   (soil_m),
    .Output         (out1),
    .Flag           (flag1)
`ifdef COMPARATOR_FAULT_LATCH_EN
    ,
    .fault_sticky   (sticky1)
`endif
  );

  comparator #(.SYNC_STAGES(2), .MIN_HOLD(4)) dut4 (
    .clk            (clk),
    .rst            (rst),
    .AirTemperature (air_t),
    .SoilTemprature (soil_t),
    .AirHumidity    (air_h),
    .SoilMoisture   (soil_m),
    .Output         (out4),
    .Flag           (flag4)
`ifdef COMPARATOR_FAULT_LATCH_EN
    ,
    .fault_sticky   (sticky4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // v = {SoilMoisture, AirHumidity, SoilTemprature, AirTemperature}
  task automatic drive(input logic [3:0] v);
    air_t  = v[0];
    soil_t = v[1];
    air_h  = v[2];
    soil_m = v[3];
  endtask

  // Directed patterns for the MIN_HOLD=1 instance: latency 3 cycles.
  typedef struct {
    logic [3:0] pat;
    logic       out;
    logic [2:0] flag;
  } vec_t;

  vec_t vecs[$];
  logic seen_high;

  initial begin
    vecs.push_back('{4'b1101, 1'b1, 3'b110});
    vecs.push_back('{4'b0101, 1'b0, 3'b101});
    vecs.push_back('{4'b1010, 1'b0, 3'b101});
    vecs.push_back('{4'b0001, 1'b0, 3'b001});
    vecs.push_back('{4'b0100, 1'b0, 3'b011});
    vecs.push_back('{4'b1000, 1'b0, 3'b100});
    vecs.push_back('{4'b0111, 1'b1, 3'b110});
    vecs.push_back('{4'b0000, 1'b0, 3'b000});

    rst = 1'b1;
    drive(4'b0000);
    #12;
    chk("reset_out", {7'd0, out1}, 8'd0);
    chk("reset_flag", {5'd0, flag1}, 8'd0);
    rst = 1'b0;
    tick(3);
    chk("idle_out", {7'd0, out1}, 8'd0);

    // all four high: not yet after 2 edges, visible after the 3rd
    drive(4'b1111);
    tick(2);
    chk("all_early_out", {7'd0, out1}, 8'd0);
    tick(1);
    chk("all_out", {7'd0, out1}, 8'd1);
    chk("all_flag", {5'd0, flag1}, 8'd7);
    drive(4'b0000);
    tick(2);
    chk("all_hold_out", {7'd0, out1}, 8'd1);
    tick(1);
    chk("clear_out", {7'd0, out1}, 8'd0);
    chk("clear_flag", {5'd0, flag1}, 8'd0);

    // lone SoilTemprature for 20 cycles
    drive(4'b0010);
    tick(20);
    chk("st_out", {7'd0, out1}, 8'd0);
    chk("st_flag", {5'd0, flag1}, 8'd2);
`ifdef COMPARATOR_FAULT_LATCH_EN
    chk("st_sticky", {4'd0, sticky1}, 8'h02);
`endif
    drive(4'b0000);
    tick(3);

    foreach (vecs[i]) begin
      drive(vecs[i].pat);
      tick(3);
      chk($sformatf("vec%0d_out", i), {7'd0, out1}, {7'd0, vecs[i].out});
      chk($sformatf("vec%0d_flag", i), {5'd0, flag1}, {5'd0, vecs[i].flag});
    end
`ifdef COMPARATOR_FAULT_LATCH_EN
    chk("all_sticky", {4'd0, sticky1}, 8'h0F);
`endif

    // MIN_HOLD=4 instance: a 2-cycle pulse must never reach the outputs
    tick(8);
    drive(4'b1111);
    tick(2);
    drive(4'b0000);
    seen_high = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (out4 !== 1'b0 || flag4 !== 3'b000) seen_high = 1'b1;
    end
    chk("pulse2_filtered", {7'd0, seen_high}, 8'd0);

    // 4-cycle pulse: appears on the 4th stable cycle (6 edges after drive)
    drive(4'b1111);
    tick(4);
    drive(4'b0000);
    tick(1);
    chk("pulse4_early_out", {7'd0, out4}, 8'd0);
    tick(1);
    chk("pulse4_out", {7'd0, out4}, 8'd1);
    chk("pulse4_flag", {5'd0, flag4}, 8'd7);
    tick(3);
    chk("pulse4_hold_out", {7'd0, out4}, 8'd1);
    tick(1);
    chk("pulse4_clear_out", {7'd0, out4}, 8'd0);
    chk("pulse4_clear_flag", {5'd0, flag4}, 8'd0);

    // reset mid-event drops outputs without a clock edge
    drive(4'b1111);
    tick(6);
    chk("pre_rst_out", {7'd0, out1}, 8'd1);
    rst = 1'b1;
    #1;
    chk("rst_out", {7'd0, out1}, 8'd0);
    chk("rst_flag", {5'd0, flag1}, 8'd0);
    chk("rst_out4", {7'd0, out4}, 8'd0);
`ifdef COMPARATOR_FAULT_LATCH_EN
    chk("rst_sticky", {4'd0, sticky1}, 8'h00);
`endif
    drive(4'b0000);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("post_rst_out", {7'd0, out1}, 8'd0);
    chk("post_rst_flag", {5'd0, flag1}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
